// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared FSM encoding and sizing helpers for seq_mul
package seq_mul_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Counter must hold WIDTH itself (the early-exit shift amount reaches it).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// rtl/seq_mul_if.sv - request/result bundle between a requester and seq_mul
interface seq_mul_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, ready, product
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, ready, product
    );
endinterface

// File: rtl/seq_mul_datapath.sv
// rtl/seq_mul_datapath.sv - magnitude capture, shift-add accumulator, sign fix
// Early completion of the trailing shifts is built only with SEQ_MUL_EARLY_EXIT_EN.
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_is_signed,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    input  logic                 i_step,
    input  logic                 i_negate,
`ifdef SEQ_MUL_EARLY_EXIT_EN
    input  logic                 i_shift_all,
    input  logic [cnt_width(WIDTH)-1:0] i_count,
    output logic                 o_rest_zero,
`endif
    output logic [2*WIDTH-1:0]   o_acc
);

    localparam int W2 = 2 * WIDTH;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [W2-1:0]    r_acc;
    logic             r_neg;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [W2:0]      w_ext;
    logic [W2-1:0]    w_next_acc;
    logic [W2-1:0]    w_neg_acc;

    // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
    assign w_a_mag = (i_is_signed && i_multiplicand[WIDTH-1]) ? (~i_multiplicand + 1'b1) : i_multiplicand;
    assign w_b_mag = (i_is_signed && i_multiplier[WIDTH-1])   ? (~i_multiplier + 1'b1)   : i_multiplier;

    assign w_sum     = {1'b0, r_acc[W2-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_ext     = {w_sum, r_acc[WIDTH-1:0]};
    assign w_neg_acc = ~r_acc + 1'b1;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] W_C = CW'(WIDTH);

    assign o_rest_zero = (r_mplier[WIDTH-1:1] == '0);
    // Remaining iterations would only shift, so do all WIDTH-count shifts now.
    assign w_next_acc  = i_shift_all ? W2'(w_ext >> (W_C - i_count)) : w_ext[W2:1];
`else
    assign w_next_acc  = w_ext[W2:1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
        end else if (i_load) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_neg    <= i_is_signed & (i_multiplicand[WIDTH-1] ^ i_multiplier[WIDTH-1]);
        end else if (i_step) begin
            r_acc    <= w_next_acc;
            r_mplier <= r_mplier >> 1;
        end else if (i_negate && r_neg) begin
            r_acc    <= w_neg_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - sequential shift-add multiplier, signed/unsigned, FSM and counter
// Optional early exit on exhausted multiplier bits: SEQ_MUL_EARLY_EXIT_EN.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    seq_mul_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [STATE_W-1:0] IDLE = ST_IDLE;
    localparam logic [STATE_W-1:0] CALC = ST_CALC;
    localparam logic [STATE_W-1:0] FIX  = ST_FIX;
    localparam logic [STATE_W-1:0] DONE = ST_DONE;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [STATE_W-1:0] r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic               w_accept;
    logic               w_step;
    logic               w_negate;
    logic               w_early;
    logic               w_calc_done;
    logic [2*WIDTH-1:0] w_acc;

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
    assign w_step   = (r_state == CALC);
    // FIX spends its first cycle on the sign fix and its second on the product write.
    assign w_negate = (r_state == FIX) && (r_count == '0);

`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic w_rest_zero;
    assign w_early = w_rest_zero;
`else
    assign w_early = 1'b0;
`endif

    assign w_calc_done = w_early || (r_count == LAST_ITER);

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_accept),
        .i_is_signed    (bus.is_signed),
        .i_multiplicand (bus.multiplicand),
        .i_multiplier   (bus.multiplier),
        .i_step         (w_step),
        .i_negate       (w_negate),
`ifdef SEQ_MUL_EARLY_EXIT_EN
        .i_shift_all    (w_early),
        .i_count        (r_count),
        .o_rest_zero    (w_rest_zero),
`endif
        .o_acc          (w_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= CALC;
                        r_count <= '0;
                    end
                end
                CALC: begin
                    if (w_calc_done) begin
                        r_state <= FIX;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                FIX: begin
                    if (r_count == '0) begin
                        r_count <= CW'(1);
                    end else begin
                        r_product <= w_acc;
                        r_state   <= DONE;
                        r_count   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state == CALC) || (r_state == FIX);
    assign bus.ready   = (r_state == DONE);
    assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - directed and randomized checks of seq_mul at WIDTH 32 and 8
module tb_seq_mul;

    logic clk;
    logic rst_n;

    seq_mul_if #(.WIDTH(32)) bus32 ();
    seq_mul_if #(.WIDTH(8))  bus8 ();

    seq_mul #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst_n), .bus(bus32));
    seq_mul #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst_n), .bus(bus8));

    int          n_checks;
    int          n_errors;
    logic [63:0] prev32;
    logic [63:0] prev8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit w8, input logic sg, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ea, eb, p;
        if (w8) begin
            ea = sg ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
            eb = sg ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
            p  = (ea * eb) & 64'hFFFF;
        end else begin
            ea = sg ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
            eb = sg ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
            p  = ea * eb;
        end
        return p;
    endfunction

    function automatic int exp_lat(input bit w8, input logic sg, input logic [63:0] b);
        int w;
        int hb;
        logic [63:0] mag;
        w   = w8 ? 8 : 32;
        mag = w8 ? {56'b0, b[7:0]} : {32'b0, b[31:0]};
        if (sg && mag[w-1]) mag = (64'd1 << w) - mag;
        hb = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) hb = i;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        return hb + 3;
`else
        return (hb >= 0) ? w + 2 : 0;
`endif
    endfunction

    function automatic logic cur_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    function automatic logic cur_ready(input bit w8);
        return w8 ? bus8.ready : bus32.ready;
    endfunction

    function automatic logic [63:0] cur_product(input bit w8);
        return w8 ? {48'b0, bus8.product} : bus32.product;
    endfunction

    task automatic set_start(input bit w8, input logic v);
        if (w8) bus8.start = v;
        else    bus32.start = v;
    endtask

    task automatic drive(input bit w8, input logic st, input logic sg, input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            bus8.start = st; bus8.is_signed = sg;
            bus8.multiplicand = a[7:0]; bus8.multiplier = b[7:0];
        end else begin
            bus32.start = st; bus32.is_signed = sg;
            bus32.multiplicand = a[31:0]; bus32.multiplier = b[31:0];
        end
    endtask

    // Called at a negedge; returns at a negedge after ready (or the cycle bound).
    task automatic run_mul(input bit w8, input logic sg, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int inj, input string tag);
        int          n;
        logic        stable;
        logic [63:0] prev;
        prev = w8 ? prev8 : prev32;
        drive(w8, 1'b1, sg, a, b);
        @(posedge clk);
        #1;
        drive(w8, 1'b0, ~sg, {$urandom, $urandom}, {$urandom, $urandom});
        check({tag, "_busy"}, 64'(cur_busy(w8)), 64'd1);
        stable = 1'b1;
        n = 0;
        while (!cur_ready(w8) && n < 200) begin
            if (cur_product(w8) !== prev) stable = 1'b0;
            set_start(w8, (n == inj - 1));
            @(posedge clk);
            #1;
            n++;
        end
        set_start(w8, 1'b0);
        check({tag, "_hold"}, 64'(stable), 64'd1);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat(w8, sg, b)));
        check({tag, "_prod"}, cur_product(w8), exp);
        if (w8) prev8 = exp;
        else    prev32 = exp;
        @(negedge clk);
    endtask

    initial begin
        logic        sg;
        logic [63:0] a, b;
        n_checks = 0;
        n_errors = 0;
        prev32   = '0;
        prev8    = '0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        check("rst_busy32", 64'(bus32.busy), 64'd0);
        check("rst_ready32", 64'(bus32.ready), 64'd0);
        check("rst_prod32", bus32.product, 64'd0);
        check("rst_ready8", 64'(bus8.ready), 64'd0);
        rst_n = 1'b1;

        run_mul(1'b0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE00000001, 0, "u_max");
        run_mul(1'b0, 1'b1, 64'hFFFFFFFD, 64'd7, 64'hFFFFFFFFFFFFFFEB, 0, "s_m3x7");
        run_mul(1'b0, 1'b1, 64'h80000000, 64'h80000000, 64'h4000000000000000, 0, "s_minxmin");
        run_mul(1'b0, 1'b1, 64'd0, 64'hFFFFFFFB, 64'd0, 0, "s_zero");
        run_mul(1'b0, 1'b0, 64'h12345678, 64'd1, 64'h12345678, 0, "u_x1");
        run_mul(1'b0, 1'b1, 64'd5, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFB, 0, "s_5xm1");
        run_mul(1'b0, 1'b0, 64'd1000, 64'h00010003, 64'h3E80BB8, 5, "busy_start");
        run_mul(1'b1, 1'b1, 64'h80, 64'h7F, 64'hC080, 0, "s8_min");
        run_mul(1'b1, 1'b0, 64'h80, 64'h7F, 64'h3F80, 0, "u8_80x7f");
        run_mul(1'b1, 1'b1, 64'h80, 64'h80, 64'h4000, 0, "s8_minxmin");
        run_mul(1'b1, 1'b0, 64'hFF, 64'hFF, 64'hFE01, 0, "u8_max");

        drive(1'b0, 1'b1, 1'b0, 64'hFFFF, 64'hFFFF);
        @(posedge clk);
        #1;
        set_start(1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy", 64'(bus32.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus32.busy), 64'd0);
        check("abort_ready", 64'(bus32.ready), 64'd0);
        check("abort_prod", bus32.product, 64'd0);
        check("abort_prod8", {48'b0, bus8.product}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        prev32 = '0;
        prev8  = '0;
        run_mul(1'b0, 1'b0, 64'd5, 64'd6, 64'd30, 0, "after_rst");

        for (int i = 0; i < 120; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = {32'b0, $urandom};
            b  = {32'b0, $urandom >> $urandom_range(0, 31)};
            run_mul(1'b0, sg, a, b, model(1'b0, sg, a, b), 0, "rand32");
        end
        for (int i = 0; i < 120; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = 64'($urandom_range(0, 255));
            b  = 64'($urandom_range(0, 255));
            run_mul(1'b1, sg, a, b, model(1'b1, sg, a, b), 0, "rand8");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
